// File: rtl/alu_if.sv
// alu_if: valid/ready operand channel and result channel between issue and alu_pipe
//   master side drives in_valid, A, B, op and out_ready
//   slave side (alu_pipe) drives in_ready, out_valid, result and the Z/N/C/V flags
interface alu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, Z, N, C, V
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, Z, N, C, V
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with single-cycle ops and iterative MUL/MULHU/DIVU/REMU
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_if slave (operand channel in, result/flag channel out)
module alu_pipe #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input logic  clk,
    input logic  reset_n,
    alu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   b_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   bm, alu_res, md_res, res_nxt, res_q;
    logic [WIDTH:0]     sum, mul_sum, r_sh, diff;
    logic [SW-1:0]      sh;
    logic               accept, is_md, md_done, load_alu;
    logic               c_alu, v_alu, c_nxt, v_nxt;
    logic               z_q, n_q, c_q, v_q, valid_q;

    assign bus.in_ready = reset_n && state == IDLE && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_md        = MULDIV_EN && bus.op >= 4'd10 && bus.op <= 4'd13;
    assign load_alu     = accept && !is_md;
    assign md_done      = state == BUSY && cnt == SW'(WIDTH - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (state == IDLE && accept && is_md) state_nxt = BUSY;
        else if (md_done)                     state_nxt = IDLE;
    end

    // ADD/SUB share one adder: SUB adds ~B plus a carry-in of op[0]
    assign bm  = bus.op[0] ? ~bus.B : bus.B;
    assign sum = {1'b0, bus.A} + {1'b0, bm} + {{WIDTH{1'b0}}, bus.op[0]};
    assign sh  = bus.B[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'd0, 4'd1: alu_res = sum[WIDTH-1:0];
            4'd2:       alu_res = bus.A | bus.B;
            4'd3:       alu_res = bus.A & bus.B;
            4'd4:       alu_res = bus.A ^ bus.B;
            4'd5:       alu_res = bus.A << sh;
            4'd6:       alu_res = bus.A >> sh;
            4'd7:       alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            4'd8:       alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            4'd9:       alu_res = WIDTH'($signed(bus.A) >>> sh);
            default:    alu_res = '0;
        endcase
    end

    assign c_alu = bus.op < 4'd2 && sum[WIDTH];
    assign v_alu = bus.op < 4'd2 && bus.A[WIDTH-1] == bm[WIDTH-1] && sum[WIDTH-1] != bus.A[WIDTH-1];

    // acc holds {hi, lo}: product high/low for multiply, remainder/quotient for divide.
    // Multiply adds B into hi when lo[0] is set then shifts right; divide shifts the
    // next dividend bit into the remainder and keeps the difference when it is non-negative.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
    assign r_sh    = acc[2*WIDTH-1:WIDTH-1];
    assign diff    = r_sh - {1'b0, b_r};
    assign acc_nxt = op_r[1] ? {mul_sum, acc[WIDTH-1:1]}
                             : {diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH]};
    // MULHU and REMU both read the high half; codes 11 and 13 share op[0]=1
    assign md_res  = op_r[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

    assign res_nxt = load_alu ? alu_res : md_res;
    assign c_nxt   = load_alu && c_alu;
    assign v_nxt   = load_alu ? v_alu : (!op_r[1] && b_r == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            acc     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                acc  <= {{WIDTH{1'b0}}, bus.A};
                b_r  <= bus.B;
                op_r <= bus.op;
                cnt  <= '0;
            end else if (state == BUSY) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
            if (load_alu || md_done) begin
                res_q   <= res_nxt;
                z_q     <= res_nxt == '0;
                n_q     <= res_nxt[WIDTH-1];
                c_q     <= c_nxt;
                v_q     <= v_nxt;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = res_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.C         = c_q;
    assign bus.V         = v_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven directed checks of alu_pipe plus handshake/reset sequences
module tb_alu_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus();

    alu_pipe #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    // f = {Z,N,C,V}; lat = sample count after the accept edge at which out_valid is first seen
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'b0, bus.Z, bus.N, bus.C, bus.V};
    endfunction

    task automatic run(input vec_t v, input int idx);
        int lat;
        bit rdy_hi;
        bus.A = v.a;
        bus.B = v.b;
        bus.op = v.op;
        bus.in_valid = 1'b1;
        lat = 0;
        while (!bus.in_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A = ~v.a;
        bus.B = ~v.b;
        bus.op = v.op ^ 4'h1;
        lat = 1;
        rdy_hi = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_hi = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_result", idx), bus.result, v.res);
        chk($sformatf("v%0d_flags", idx), flags(), {28'b0, v.f});
        if (v.lat > 1) chk($sformatf("v%0d_busy_ready", idx), 32'(rdy_hi), 32'd0);
    endtask

    initial begin
        bit seen;
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 4'd0,  32'h80000000, 4'b0101, 1});
        vecs.push_back('{32'h00000005, 32'h00000005, 4'd1,  32'h00000000, 4'b1010, 1});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 4'd0,  32'h00000000, 4'b1010, 1});
        vecs.push_back('{32'h00000000, 32'h00000001, 4'd1,  32'hFFFFFFFF, 4'b0100, 1});
        vecs.push_back('{32'h80000000, 32'h00000001, 4'd1,  32'h7FFFFFFF, 4'b0011, 1});
        vecs.push_back('{32'h0000F0F0, 32'h00000F0F, 4'd2,  32'h0000FFFF, 4'b0000, 1});
        vecs.push_back('{32'hFF00FF00, 32'h0FF00FF0, 4'd3,  32'h0F000F00, 4'b0000, 1});
        vecs.push_back('{32'hAAAAAAAA, 32'hFFFFFFFF, 4'd4,  32'h55555555, 4'b0000, 1});
        vecs.push_back('{32'h00000001, 32'd31,       4'd5,  32'h80000000, 4'b0100, 1});
        vecs.push_back('{32'h00000001, 32'h00000021, 4'd5,  32'h00000002, 4'b0000, 1});
        vecs.push_back('{32'h80000000, 32'd31,       4'd6,  32'h00000001, 4'b0000, 1});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 4'd7,  32'h00000001, 4'b0000, 1});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 4'd8,  32'h00000000, 4'b1000, 1});
        vecs.push_back('{32'h80000000, 32'd4,        4'd9,  32'hF8000000, 4'b0100, 1});
        vecs.push_back('{32'h40000000, 32'd4,        4'd9,  32'h04000000, 4'b0000, 1});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000002, 4'd10, 32'hFFFFFFFE, 4'b0100, 33});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000002, 4'd11, 32'h00000001, 4'b0000, 33});
        vecs.push_back('{32'h00010000, 32'h00010000, 4'd10, 32'h00000000, 4'b1000, 33});
        vecs.push_back('{32'h00010000, 32'h00010000, 4'd11, 32'h00000001, 4'b0000, 33});
        vecs.push_back('{32'd100,      32'd7,        4'd12, 32'd14,       4'b0000, 33});
        vecs.push_back('{32'd100,      32'd7,        4'd13, 32'd2,        4'b0000, 33});
        vecs.push_back('{32'd9,        32'd0,        4'd12, 32'hFFFFFFFF, 4'b0101, 33});
        vecs.push_back('{32'd9,        32'd0,        4'd13, 32'd9,        4'b0001, 33});
        vecs.push_back('{32'h00000001, 32'h00000002, 4'd14, 32'h00000000, 4'b1000, 1});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 32'h00000000, 4'b1000, 1});

        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.op = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", flags(), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) run(vecs[i], i);

        // back-to-back single-cycle ops with out_ready held high
        @(posedge clk); #1;
        bus.A = 32'd5; bus.B = 32'd5; bus.op = 4'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 32'hFFFFFFFF; bus.B = 32'd1; bus.op = 4'd0;
        chk("bb_sub_valid", 32'(bus.out_valid), 32'd1);
        chk("bb_sub_result", bus.result, 32'd0);
        chk("bb_sub_flags", flags(), 32'b1010);
        chk("bb_sub_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.A = 32'd1; bus.B = 32'd2; bus.op = 4'd2;
        chk("bb_add_valid", 32'(bus.out_valid), 32'd1);
        chk("bb_add_result", bus.result, 32'd0);
        chk("bb_add_flags", flags(), 32'b1010);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bb_or_valid", 32'(bus.out_valid), 32'd1);
        chk("bb_or_result", bus.result, 32'd3);
        @(posedge clk); #1;
        chk("bb_drain_valid", 32'(bus.out_valid), 32'd0);

        // SRA result held under backpressure
        bus.out_ready = 1'b0;
        bus.A = 32'h80000000; bus.B = 32'd4; bus.op = 4'd9; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 32'd1; bus.B = 32'd1; bus.op = 4'd0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d_result", k), bus.result, 32'hF8000000);
            chk($sformatf("hold%0d_flags", k), flags(), 32'b0100);
            chk($sformatf("hold%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("hold_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_drain_result", bus.result, 32'hF8000000);

        // reset during a divide
        bus.A = 32'd100; bus.B = 32'd7; bus.op = 4'd12; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_result", bus.result, 32'd0);
        chk("mid_rst_flags", flags(), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        run('{32'd1, 32'd2, 4'd8, 32'd1, 4'b0000, 1}, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
